// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Combinational lookup for IF, resolution/training port for EX/MEM.
module branch_target_predictor #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lookup_valid,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            update_valid,
  input  logic [XLEN-1:0] update_pc,
  input  logic            update_is_branch,
  input  logic            update_taken,
  input  logic [XLEN-1:0] update_target,
  input  logic [XLEN-1:0] update_pred_target,
  input  logic            flush,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_mispredicts
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;

  localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_WT  =
    CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);

  logic [ENTRIES-1:0]  valid_q;
  logic [ENTRIES-1:0]  uncond_q;
  logic [TAGW-1:0]     tag_q    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
  logic [31:0]         lookups_q;
  logic [31:0]         mispredicts_q;

  logic [IDX-1:0]      l_idx;
  logic [TAGW-1:0]     l_tag;
  logic                l_hit;
  logic [IDX-1:0]      u_idx;
  logic [TAGW-1:0]     u_tag;
  logic                u_hit;
  logic [CTR_BITS-1:0] u_ctr;
  logic [XLEN-1:0]     actual_next;
  logic                unused_ok;

  assign l_idx = lookup_pc[IDX+1:2];
  assign l_tag = lookup_pc[XLEN-1:IDX+2];
  assign l_hit = lookup_valid & valid_q[l_idx]
               & (tag_q[l_idx] == l_tag);

  assign pred_taken  = l_hit
                     & (uncond_q[l_idx] | ctr_q[l_idx][CTR_BITS-1]);
  assign pred_target = pred_taken ? target_q[l_idx]
                                  : lookup_pc + XLEN'(4);

  assign u_idx = update_pc[IDX+1:2];
  assign u_tag = update_pc[XLEN-1:IDX+2];
  assign u_hit = valid_q[u_idx] & (tag_q[u_idx] == u_tag);
  assign u_ctr = ctr_q[u_idx];

  assign actual_next = update_taken ? update_target
                                    : update_pc + XLEN'(4);
  assign mispredict  = update_valid
                     & (actual_next != update_pred_target);
  assign redirect_pc = actual_next;

  assign unused_ok = ^{lookup_pc[1:0], update_pc[1:0]};

  // Valid bits and counters carry reset; flush only drops valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_WNT;
    end else if (flush) begin
      valid_q <= '0;
    end else if (update_valid) begin
      if (update_taken) begin
        valid_q[u_idx] <= 1'b1;
        if (!u_hit)
          ctr_q[u_idx] <= CTR_WT;
        else if (u_ctr != CTR_MAX)
          ctr_q[u_idx] <= u_ctr + CTR_BITS'(1);
      end else if (u_hit && u_ctr != '0) begin
        ctr_q[u_idx] <= u_ctr - CTR_BITS'(1);
      end
    end
  end

  // Payload is meaningless while the valid bit is clear, so no reset.
  always_ff @(posedge clk) begin
    if (!flush && update_valid && update_taken) begin
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= update_target;
      uncond_q[u_idx] <= ~update_is_branch;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lookups_q     <= '0;
      mispredicts_q <= '0;
    end else begin
      if (lookup_valid && lookups_q != 32'hFFFF_FFFF)
        lookups_q <= lookups_q + 32'd1;
      if (mispredict && mispredicts_q != 32'hFFFF_FFFF)
        mispredicts_q <= mispredicts_q + 32'd1;
    end
  end

  assign stat_lookups     = lookups_q;
  assign stat_mispredicts = mispredicts_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed and randomized checks of branch_target_predictor
// against a table-level reference model.
module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_is_branch;
  logic        update_taken;
  logic [31:0] update_target;
  logic [31:0] update_pred_target;
  logic        flush;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] stat_lookups;
  logic [31:0] stat_mispredicts;

  int checks   = 0;
  int failures = 0;

  branch_target_predictor #(
    .XLEN(32), .ENTRIES(16), .CTR_BITS(2)
  ) dut (
    .clk(clk), .rst(rst),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .update_valid(update_valid), .update_pc(update_pc),
    .update_is_branch(update_is_branch),
    .update_taken(update_taken),
    .update_target(update_target),
    .update_pred_target(update_pred_target),
    .flush(flush),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_lookups(stat_lookups),
    .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  // Reference model: 16 entries, counters 0..3, taken when >= 2
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  bit          m_unc   [16];
  int          m_ctr   [16];
  longint      m_look;
  longint      m_misp;

  function automatic int m_index(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 1;
    end
    m_look = 0;
    m_misp = 0;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    int i = m_index(pc);
    return m_valid[i] && (m_tag[i] == (pc >> 6));
  endfunction

  function automatic void m_pred(input logic [31:0] pc,
                                 input bit v,
                                 output bit tk,
                                 output logic [31:0] nt);
    int i = m_index(pc);
    tk = v && m_hit(pc) && (m_unc[i] || m_ctr[i] >= 2);
    nt = tk ? m_tgt[i] : pc + 32'd4;
  endfunction

  function automatic logic [31:0] m_actual();
    return update_taken ? update_target : update_pc + 32'd4;
  endfunction

  function automatic bit m_misp_now();
    return update_valid && (m_actual() != update_pred_target);
  endfunction

  function automatic void m_edge();
    int i = m_index(update_pc);
    bit h = m_hit(update_pc);
    if (lookup_valid && m_look < 64'hFFFF_FFFF) m_look++;
    if (m_misp_now() && m_misp < 64'hFFFF_FFFF) m_misp++;
    if (flush) begin
      for (int k = 0; k < 16; k++) m_valid[k] = 0;
    end else if (update_valid) begin
      if (update_taken) begin
        m_ctr[i]   = h ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : 2;
        m_valid[i] = 1;
        m_tag[i]   = update_pc >> 6;
        m_tgt[i]   = update_target;
        m_unc[i]   = !update_is_branch;
      end else if (h && m_ctr[i] > 0) begin
        m_ctr[i] = m_ctr[i] - 1;
      end
    end
  endfunction

  task automatic idle();
    lookup_valid       = 1'b0;
    lookup_pc          = '0;
    update_valid       = 1'b0;
    update_pc          = '0;
    update_is_branch   = 1'b1;
    update_taken       = 1'b0;
    update_target      = '0;
    update_pred_target = '0;
    flush              = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    @(negedge clk);
    idle();
  endtask

  task automatic upd(input logic [31:0] pc, input bit br,
                     input bit tk, input logic [31:0] tgt,
                     input logic [31:0] ptgt);
    update_valid       = 1'b1;
    update_pc          = pc;
    update_is_branch   = br;
    update_taken       = tk;
    update_target      = tgt;
    update_pred_target = ptgt;
  endtask

  task automatic look(input logic [31:0] pc);
    lookup_valid = 1'b1;
    lookup_pc    = pc;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    look(32'h40);
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL reset_pred_taken got=%0b exp=0", pred_taken);
    end
    checks++;
    if (pred_target !== 32'h44) begin
      failures++;
      $display("FAIL reset_pred_target got=%h exp=00000044",
               pred_target);
    end
    tick();
    #1;
    checks++;
    if (stat_lookups !== 32'd1 || stat_mispredicts !== 32'd0) begin
      failures++;
      $display("FAIL reset_stats got=%0d/%0d exp=1/0",
               stat_lookups, stat_mispredicts);
    end
  endtask

  task automatic test_allocation();
    upd(32'h40, 1, 1, 32'h10, 32'h44);
    #1;
    checks++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h10) begin
      failures++;
      $display("FAIL alloc_misp got=%0b/%h exp=1/00000010",
               mispredict, redirect_pc);
    end
    tick();
    look(32'h40);
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h10) begin
      failures++;
      $display("FAIL alloc_lookup got=%0b/%h exp=1/00000010",
               pred_taken, pred_target);
    end
    tick();
  endtask

  task automatic test_hysteresis();
    for (int k = 0; k < 3; k++) begin
      upd(32'h40, 1, 1, 32'h10, 32'h10);
      tick();
    end
    upd(32'h40, 1, 0, 32'h10, 32'h10);
    #1;
    checks++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h44) begin
      failures++;
      $display("FAIL hyst_misp got=%0b/%h exp=1/00000044",
               mispredict, redirect_pc);
    end
    tick();
    look(32'h40);
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h10) begin
      failures++;
      $display("FAIL hyst_first_nt got=%0b/%h exp=1/00000010",
               pred_taken, pred_target);
    end
    upd(32'h40, 1, 0, 32'h10, 32'h10);
    tick();
    look(32'h40);
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h44) begin
      failures++;
      $display("FAIL hyst_second_nt got=%0b/%h exp=0/00000044",
               pred_taken, pred_target);
    end
    tick();
  endtask

  task automatic test_aliasing();
    upd(32'h40, 1, 1, 32'h10, 32'h44);
    tick();
    upd(32'h80, 1, 1, 32'h300, 32'h84);
    tick();
    look(32'h40);
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h44) begin
      failures++;
      $display("FAIL alias_evicted got=%0b/%h exp=0/00000044",
               pred_taken, pred_target);
    end
    look(32'h80);
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h300) begin
      failures++;
      $display("FAIL alias_new got=%0b/%h exp=1/00000300",
               pred_taken, pred_target);
    end
    tick();
  endtask

  task automatic test_jal();
    upd(32'h100, 0, 1, 32'h200, 32'h104);
    look(32'h100);
    #1;
    checks++;
    if (pred_target !== 32'h104 || mispredict !== 1'b1) begin
      failures++;
      $display("FAIL jal_same_cycle got=%h/%0b exp=00000104/1",
               pred_target, mispredict);
    end
    @(posedge clk);
    m_edge();
    @(negedge clk);
    update_valid = 1'b0;
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin
      failures++;
      $display("FAIL jal_next_cycle got=%0b/%h exp=1/00000200",
               pred_taken, pred_target);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      upd(32'h100, 1, 0, 32'h200, 32'h200);
      tick();
    end
    look(32'h100);
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin
      failures++;
      $display("FAIL jal_uncond_ctr0 got=%0b/%h exp=1/00000200",
               pred_taken, pred_target);
    end
    tick();
  endtask

  task automatic test_flush();
    longint sl, sm;
    upd(32'h40, 1, 1, 32'h10, 32'h44);
    tick();
    flush = 1'b1;
    upd(32'h80, 1, 1, 32'h300, 32'h84);
    tick();
    sl = m_look;
    sm = m_misp;
    look(32'h40);
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h44) begin
      failures++;
      $display("FAIL flush_miss_40 got=%0b/%h exp=0/00000044",
               pred_taken, pred_target);
    end
    look(32'h80);
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h84) begin
      failures++;
      $display("FAIL flush_miss_80 got=%0b/%h exp=0/00000084",
               pred_taken, pred_target);
    end
    checks++;
    if (stat_lookups !== 32'(sl) || stat_mispredicts !== 32'(sm)) begin
      failures++;
      $display("FAIL flush_stats got=%0d/%0d exp=%0d/%0d",
               stat_lookups, stat_mispredicts, sl, sm);
    end
    tick();
  endtask

  task automatic test_stat_saturation();
    force dut.lookups_q = 32'hFFFF_FFFE;
    #1;
    release dut.lookups_q;
    m_look = 64'hFFFF_FFFE;
    for (int k = 0; k < 3; k++) begin
      look(32'h40 + 32'(k * 4));
      tick();
      #1;
      checks++;
      if (stat_lookups !== 32'hFFFF_FFFF) begin
        failures++;
        $display("FAIL stat_sat cycle=%0d got=%h exp=ffffffff",
                 k, stat_lookups);
      end
    end
  endtask

  task automatic test_random();
    bit          tk;
    logic [31:0] nt;
    logic [31:0] pc;
    for (int n = 0; n < 400; n++) begin
      pc = 32'(($urandom_range(0, 3) << 6)
         | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
      lookup_valid = 1'($urandom_range(0, 3) != 0);
      lookup_pc    = pc;
      pc = 32'(($urandom_range(0, 3) << 6)
         | ($urandom_range(0, 3) << 2));
      update_valid     = 1'($urandom_range(0, 1));
      update_pc        = pc;
      update_is_branch = 1'($urandom_range(0, 4) != 0);
      update_taken     = update_is_branch ? 1'($urandom_range(0, 1))
                                          : 1'b1;
      update_target    = 32'($urandom_range(0, 7) << 4);
      m_pred(pc, 1, tk, nt);
      update_pred_target = ($urandom_range(0, 3) != 0)
                         ? nt : 32'($urandom_range(0, 7) << 4);
      flush = 1'($urandom_range(0, 40) == 0);
      #1;
      m_pred(lookup_pc, lookup_valid, tk, nt);
      checks++;
      if (pred_taken !== tk || pred_target !== nt) begin
        failures++;
        $display("FAIL rand_lookup n=%0d pc=%h got=%0b/%h exp=%0b/%h",
                 n, lookup_pc, pred_taken, pred_target, tk, nt);
      end
      checks++;
      if (mispredict !== m_misp_now()
          || (mispredict && redirect_pc !== m_actual())) begin
        failures++;
        $display("FAIL rand_update n=%0d got=%0b/%h exp=%0b/%h",
                 n, mispredict, redirect_pc, m_misp_now(),
                 m_actual());
      end
      checks++;
      if (stat_lookups !== 32'(m_look)
          || stat_mispredicts !== 32'(m_misp)) begin
        failures++;
        $display("FAIL rand_stats n=%0d got=%0d/%0d exp=%0d/%0d",
                 n, stat_lookups, stat_mispredicts, m_look, m_misp);
      end
      tick();
    end
  endtask

  task automatic test_reset_midrun();
    upd(32'h80, 1, 1, 32'h300, 32'h84);
    tick();
    look(32'h80);
    upd(32'h40, 1, 1, 32'h10, 32'h44);
    #2;
    rst = 1'b1;
    m_reset();
    #1;
    checks++;
    if (stat_lookups !== 32'd0 || stat_mispredicts !== 32'd0) begin
      failures++;
      $display("FAIL midrst_stats got=%0d/%0d exp=0/0",
               stat_lookups, stat_mispredicts);
    end
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h84) begin
      failures++;
      $display("FAIL midrst_lookup got=%0b/%h exp=0/00000084",
               pred_taken, pred_target);
    end
    checks++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h10) begin
      failures++;
      $display("FAIL midrst_comb got=%0b/%h exp=1/00000010",
               mispredict, redirect_pc);
    end
    @(negedge clk);
    idle();
    rst = 1'b0;
    look(32'h80);
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h84) begin
      failures++;
      $display("FAIL postrst_lookup got=%0b/%h exp=0/00000084",
               pred_taken, pred_target);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_allocation();
    test_hysteresis();
    test_aliasing();
    test_jal();
    test_flush();
    test_stat_saturation();
    test_random();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
